deck_addr_gen: RTL and testbench

Free-running entropy counter plus card-address scrambler for the BlackJack deck logic. A WIDTH-bit counter clocked at 2 kHz times the ~2 s game delay (`o_TwoSec`) and keeps counting while the player holds reset, so its value acts as a random seed. A combinational mapper uses that seed to turn a sequential deck index `a_i` (0..51) into a scrambled card address `a_j` (0..51). For a fixed seed, the mapping is a permutation of the 52 cards.

---
 rtl/deck_addr_gen.sv | 59 +++++
 tb/tb_deck_addr_gen.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/deck_addr_gen.sv
// Free-running entropy counter and seed-driven card-address scrambler.
// The counter times the two-second delay and seeds the 52-card permutation.
module deck_addr_gen #(
   parameter int WIDTH = 12
) (
   input  logic             clk_2K,
   input  logic             i_Reset,
   input  logic             i_RstCounter,
   input  logic             i_ActCounter,
   input  logic [5:0]       a_i,
   output logic [WIDTH-1:0] o_Count,
   output logic             o_TwoSec,
   output logic [5:0]       a_j
);

   logic [5:0] a;
   logic [4:0] m;
   logic [5:0] k;
   logic [9:0] sum;
   logic [9:0] sum_mod;

   // i_Reset is the player reset: it keeps the counter running to gather entropy.
   always_ff @(posedge clk_2K) begin
      if (i_RstCounter) begin
         o_Count  <= '0;
         o_TwoSec <= 1'b0;
      end else if (!i_Reset) begin
         o_Count  <= o_Count + 1'b1;
         o_TwoSec <= 1'b0;
      end else if (i_ActCounter) begin
         o_Count <= o_Count + 1'b1;
         if (o_Count == {WIDTH{1'b1}}) begin
            o_TwoSec <= 1'b1;
         end
      end
   end

   always_comb begin
      a = (a_i < 6'd52) ? a_i : a_i - 6'd52;
      k = (o_Count[5:0] < 6'd52) ? o_Count[5:0] : o_Count[5:0] - 6'd52;
      m = 5'd1;
      // Every multiplier is coprime to 52, so m*a+k is a permutation mod 52.
      case (o_Count[7:5])
         3'd0:    m = 5'd1;
         3'd1:    m = 5'd3;
         3'd2:    m = 5'd5;
         3'd3:    m = 5'd7;
         3'd4:    m = 5'd9;
         3'd5:    m = 5'd11;
         3'd6:    m = 5'd15;
         default: m = 5'd17;
      endcase
      // Worst case 17*51+51 = 918 needs ten bits.
      sum     = 10'(m) * 10'(a) + 10'(k);
      sum_mod = sum % 10'd52;
      a_j     = sum_mod[5:0];
   end

endmodule

// File: tb/tb_deck_addr_gen.sv
// Directed bench for deck_addr_gen: counter priority and timing, mapper vectors
// and permutation sweeps over several seeds.
module tb_deck_addr_gen;

   localparam int WIDTH = 12;

   logic             clk_2K;
   logic             i_Reset;
   logic             i_RstCounter;
   logic             i_ActCounter;
   logic [5:0]       a_i;
   logic [WIDTH-1:0] o_Count;
   logic             o_TwoSec;
   logic [5:0]       a_j;

   int checks;
   int failures;
   int exp_cnt;

   typedef struct {
      int         cnt;
      logic [5:0] ai;
      logic [5:0] exp_aj;
   } vec_t;

   vec_t vecs[15];

   deck_addr_gen #(.WIDTH(WIDTH)) dut (
      .clk_2K(clk_2K),
      .i_Reset(i_Reset),
      .i_RstCounter(i_RstCounter),
      .i_ActCounter(i_ActCounter),
      .a_i(a_i),
      .o_Count(o_Count),
      .o_TwoSec(o_TwoSec),
      .a_j(a_j)
   );

   initial clk_2K = 1'b0;
   always #5 clk_2K = ~clk_2K;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_2K);
      #1;
   endtask

   task automatic clear();
      i_RstCounter = 1'b1;
      tick();
      i_RstCounter = 1'b0;
      exp_cnt = 0;
   endtask

   task automatic advance_to(input int target);
      i_ActCounter = 1'b1;
      while (exp_cnt != target) begin
         tick();
         exp_cnt = (exp_cnt + 1) % 4096;
      end
      i_ActCounter = 1'b0;
   endtask

   initial begin
      int r;
      int prev;
      int seeds[4];
      logic [51:0] seen;

      checks = 0;
      failures = 0;
      exp_cnt = 0;
      i_Reset = 1'b1;
      i_RstCounter = 1'b0;
      i_ActCounter = 1'b0;
      a_i = 6'd0;
      repeat (2) tick();

      // Clear
      clear();
      check("clear_count", int'(o_Count), 0);
      check("clear_twosec", int'(o_TwoSec), 0);

      // Mapper vectors, ascending seed order so the counter only counts up
      vecs[0]  = '{0,   6'd0,  6'd0};
      vecs[1]  = '{0,   6'd5,  6'd5};
      vecs[2]  = '{0,   6'd51, 6'd51};
      vecs[3]  = '{0,   6'd52, 6'd0};
      vecs[4]  = '{0,   6'd63, 6'd11};
      vecs[5]  = '{165, 6'd0,  6'd37};
      vecs[6]  = '{165, 6'd1,  6'd48};
      vecs[7]  = '{165, 6'd2,  6'd7};
      vecs[8]  = '{165, 6'd51, 6'd26};
      vecs[9]  = '{165, 6'd52, 6'd37};
      vecs[10] = '{165, 6'd63, 6'd2};
      vecs[11] = '{255, 6'd0,  6'd11};
      vecs[12] = '{255, 6'd3,  6'd10};
      vecs[13] = '{255, 6'd10, 6'd25};
      vecs[14] = '{255, 6'd51, 6'd46};
      for (int i = 0; i < 15; i++) begin
         advance_to(vecs[i].cnt);
         a_i = vecs[i].ai;
         #1;
         check($sformatf("vec%0d_count", i), int'(o_Count), vecs[i].cnt);
         check($sformatf("vec%0d_aj", i), int'(a_j), int'(vecs[i].exp_aj));
      end

      // Two-second timing
      clear();
      i_ActCounter = 1'b1;
      repeat (4095) tick();
      check("pre_wrap_count", int'(o_Count), 4095);
      check("pre_wrap_twosec", int'(o_TwoSec), 0);
      tick();
      check("wrap_count", int'(o_Count), 0);
      check("wrap_twosec", int'(o_TwoSec), 1);
      i_ActCounter = 1'b0;
      repeat (5) tick();
      check("hold_count", int'(o_Count), 0);
      check("hold_twosec", int'(o_TwoSec), 1);
      i_ActCounter = 1'b1;
      tick();
      i_ActCounter = 1'b0;
      check("sticky_count", int'(o_Count), 1);
      check("sticky_twosec", int'(o_TwoSec), 1);
      clear();
      check("rst_twosec", int'(o_TwoSec), 0);
      check("rst_count", int'(o_Count), 0);

      // Player reset from V=100 with the sticky flag set
      i_ActCounter = 1'b1;
      repeat (4096) tick();
      exp_cnt = 0;
      advance_to(100);
      check("pr_start_twosec", int'(o_TwoSec), 1);
      r = $urandom_range(0, 4999);
      i_Reset = 1'b0;
      repeat (r) tick();
      i_Reset = 1'b1;
      exp_cnt = (100 + r) % 4096;
      check("pr_count", int'(o_Count), exp_cnt);
      check("pr_twosec", int'(o_TwoSec), (r > 0) ? 0 : 1);
      repeat (3) tick();
      check("pr_release_hold", int'(o_Count), exp_cnt);

      // Player reset together with count enable: one increment per edge
      i_Reset = 1'b0;
      i_ActCounter = 1'b1;
      tick();
      i_Reset = 1'b1;
      i_ActCounter = 1'b0;
      exp_cnt = (exp_cnt + 1) % 4096;
      check("pr_act_single_inc", int'(o_Count), exp_cnt);
      check("pr_act_twosec", int'(o_TwoSec), 0);

      // Priority: clear beats player reset
      i_RstCounter = 1'b1;
      i_Reset = 1'b0;
      tick();
      i_RstCounter = 1'b0;
      i_Reset = 1'b1;
      exp_cnt = 0;
      check("prio_count", int'(o_Count), 0);

      // Permutation sweeps
      seeds[0] = 37;
      seeds[1] = 1000;
      seeds[2] = 2222;
      seeds[3] = 4095;
      for (int s = 0; s < 4; s++) begin
         advance_to(seeds[s]);
         seen = '0;
         prev = -1;
         for (int i = 0; i <= 52; i++) begin
            a_i = 6'(i);
            tick();
            check($sformatf("sweep%0d_count_a%0d", s, i), int'(o_Count), seeds[s]);
            check($sformatf("sweep%0d_range_a%0d", s, i), int'(a_j < 6'd52), 1);
            check($sformatf("sweep%0d_consec_a%0d", s, i), int'(int'(a_j) != prev), 1);
            if (i < 52 && a_j < 6'd52) begin
               check($sformatf("sweep%0d_unique_a%0d", s, i), int'(seen[a_j]), 0);
               seen[a_j] = 1'b1;
            end
            prev = int'(a_j);
         end
         check($sformatf("sweep%0d_all_hit", s), int'(&seen), 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
